// File: rtl/inst_fetch.sv
// inst_fetch: takes a PC over valid/ready, fetches its word over a req/gnt/rvalid memory port
// and holds it for decode. Define IFU_TIMEOUT_EN to add the memory-response timeout.
module inst_fetch #(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_INST = 32'h00000013,
  parameter int                TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] pc,
  input  logic              pc_valid,
  output logic              pc_ready,
  input  logic              flush,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] inst,
  output logic [DATA_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic              inst_fault
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] inst_reg, inst_next;
  logic [DATA_W-1:0] inst_pc_reg, inst_pc_next;
  logic              fault_reg, fault_next;
  logic              drop_reg, drop_next;
  logic              pc_ready_reg, pc_ready_next;

`ifdef IFU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             timed_out;

  // Counter starts at 0 on the first WAIT cycle, so TIMEOUT-1 marks the last allowed cycle.
  assign timed_out = (cnt_reg == CNT_W'(TIMEOUT - 1));
`endif

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    inst_next     = inst_reg;
    inst_pc_next  = inst_pc_reg;
    fault_next    = fault_reg;
    drop_next     = drop_reg;
    pc_ready_next = 1'b0;
`ifdef IFU_TIMEOUT_EN
    cnt_next      = cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        // While pc_ready is high the PC register has not advanced yet; do not refetch it.
        if (pc_valid && !flush && !pc_ready_reg) begin
          addr_next = pc;
          if (pc[1:0] != 2'b00) begin
            inst_next    = NOP_INST;
            inst_pc_next = pc;
            fault_next   = 1'b1;
            state_next   = HOLD;
          end else begin
            state_next = REQ;
          end
        end
      end
      REQ: begin
        if (flush) drop_next = 1'b1;
        if (imem_gnt) begin
          state_next = WAIT;
`ifdef IFU_TIMEOUT_EN
          cnt_next   = '0;
`endif
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (drop_reg || flush) begin
            drop_next  = 1'b0;
            state_next = IDLE;
          end else begin
            inst_next    = imem_rdata;
            inst_pc_next = addr_reg;
            fault_next   = 1'b0;
            state_next   = HOLD;
          end
        end
`ifdef IFU_TIMEOUT_EN
        else if (timed_out) begin
          drop_next = 1'b0;
          if (drop_reg || flush) begin
            state_next = IDLE;
          end else begin
            inst_next    = NOP_INST;
            inst_pc_next = addr_reg;
            fault_next   = 1'b1;
            state_next   = HOLD;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
          if (flush) drop_next = 1'b1;
        end
`else
        else if (flush) begin
          drop_next = 1'b1;
        end
`endif
      end
      HOLD: begin
        if (flush) begin
          state_next = IDLE;
        end else if (inst_ready) begin
          pc_ready_next = 1'b1;
          state_next    = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      inst_reg     <= '0;
      inst_pc_reg  <= '0;
      fault_reg    <= 1'b0;
      drop_reg     <= 1'b0;
      pc_ready_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      inst_reg     <= inst_next;
      inst_pc_reg  <= inst_pc_next;
      fault_reg    <= fault_next;
      drop_reg     <= drop_next;
      pc_ready_reg <= pc_ready_next;
    end
  end

`ifdef IFU_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_reg <= '0;
    else        cnt_reg <= cnt_next;
  end
`endif

  assign imem_req   = (state_reg == REQ);
  assign imem_addr  = addr_reg;
  assign inst       = inst_reg;
  assign inst_pc    = inst_pc_reg;
  assign inst_fault = fault_reg;
  assign pc_ready   = pc_ready_reg;
  // A flush cycle must never complete a decode handshake.
  assign inst_valid = (state_reg == HOLD) && !flush;

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed fetch vectors; expected words go into a scoreboard queue that a
// separate monitor checks whenever inst_valid is presented. Honours IFU_TIMEOUT_EN.
module tb_inst_fetch;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk, rst_n;
  logic [31:0] pc;
  logic        pc_valid, pc_ready, flush;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] inst, inst_pc;
  logic        inst_valid, inst_ready, inst_fault;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  inst_fetch #(.DATA_W(32), .NOP_INST(NOP), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .flush(flush), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .inst(inst), .inst_pc(inst_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_fault(inst_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string name);
    chk(imem_req == 1'b0,   {name, "_imem_req"},   32'(imem_req),   0);
    chk(imem_addr == 32'h0, {name, "_imem_addr"},  imem_addr,       0);
    chk(inst == 32'h0,      {name, "_inst"},       inst,            0);
    chk(inst_pc == 32'h0,   {name, "_inst_pc"},    inst_pc,         0);
    chk(inst_valid == 1'b0, {name, "_inst_valid"}, 32'(inst_valid), 0);
    chk(inst_fault == 1'b0, {name, "_inst_fault"}, 32'(inst_fault), 0);
    chk(pc_ready == 1'b0,   {name, "_pc_ready"},   32'(pc_ready),   0);
  endtask

  // Monitor: compare every presented word with the scoreboard head; pop on handshake.
  initial begin : monitor
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && inst_valid) begin
        if (sb.size() == 0) begin
          chk(1'b0, "unexpected_inst_valid", inst, 32'h0);
        end else begin
          chk(inst == sb[0].inst,        "inst",       inst,            sb[0].inst);
          chk(inst_pc == sb[0].pc,       "inst_pc",    inst_pc,         sb[0].pc);
          chk(inst_fault == sb[0].fault, "inst_fault", 32'(inst_fault), 32'(sb[0].fault));
          if (inst_ready) begin
            $display("fetch pc=0x%08h inst=0x%08h fault=%0d", inst_pc, inst, inst_fault);
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  // Full fetch: delays counted in cycles; returns after the pc_ready pulse has ended.
  task automatic fetch(input logic [31:0] a, input int gnt_dly, input int rv_dly,
                       input int rdy_dly, input logic [31:0] data);
    bit   mis;
    exp_t e;
    mis = (a[1:0] != 2'b00);
    e.inst  = mis ? NOP : data;
    e.pc    = a;
    e.fault = mis;
    sb.push_back(e);
    pc = a;
    pc_valid = 1'b1;
    tick();
    if (!mis) begin
      for (int i = 0; i < gnt_dly; i++) begin
        chk(imem_req == 1'b1, "req_stable", 32'(imem_req), 1);
        chk(imem_addr == a, "addr_stable", imem_addr, a);
        tick();
      end
      chk(imem_req == 1'b1, "req", 32'(imem_req), 1);
      chk(imem_addr == a, "addr", imem_addr, a);
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      for (int i = 0; i < rv_dly; i++) begin
        chk(imem_req == 1'b0, "req_off_wait", 32'(imem_req), 0);
        chk(inst_valid == 1'b0, "valid_early", 32'(inst_valid), 0);
        tick();
      end
      imem_rvalid = 1'b1;
      imem_rdata = data;
      tick();
      imem_rvalid = 1'b0;
    end else begin
      chk(imem_req == 1'b0, "misaligned_no_req", 32'(imem_req), 0);
    end
    chk(inst_valid == 1'b1, "valid_latency", 32'(inst_valid), 1);
    for (int i = 0; i < rdy_dly; i++) begin
      chk(pc_ready == 1'b0, "pc_ready_before_accept", 32'(pc_ready), 0);
      tick();
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    pc_valid = 1'b0;
    chk(pc_ready == 1'b1, "pc_ready_pulse", 32'(pc_ready), 1);
    chk(inst_valid == 1'b0, "valid_after_accept", 32'(inst_valid), 0);
    tick();
    chk(pc_ready == 1'b0, "pc_ready_one_cycle", 32'(pc_ready), 0);
  endtask

  initial begin : stimulus
    rst_n = 1'b0; pc = 32'h0; pc_valid = 1'b0; flush = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; inst_ready = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    fetch(32'h80000000, 0, 0, 0, 32'h00500093);
    fetch(32'h80000004, 3, 2, 4, 32'h00a00113);

    // Flush one cycle after grant: response must be discarded.
    pc = 32'h80000008; pc_valid = 1'b1;
    tick();
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; flush = 1'b1; pc_valid = 1'b0;
    tick();
    flush = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF;
    tick();
    imem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk(inst_valid == 1'b0, "flush_wait_no_valid", 32'(inst_valid), 0);
      chk(pc_ready == 1'b0, "flush_wait_no_pc_ready", 32'(pc_ready), 0);
      tick();
    end
    fetch(32'h80000010, 0, 0, 0, 32'h00c00193);

    // Flush while the request is pending: request stays up, result dropped.
    pc = 32'h80000014; pc_valid = 1'b1;
    tick();
    flush = 1'b1; pc_valid = 1'b0;
    tick();
    flush = 1'b0;
    chk(imem_req == 1'b1, "flush_req_not_withdrawn", 32'(imem_req), 1);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hCAFEF00D;
    tick();
    imem_rvalid = 1'b0;
    chk(inst_valid == 1'b0, "flush_req_no_valid", 32'(inst_valid), 0);
    tick();
    fetch(32'h80000018, 1, 1, 1, 32'h00208233);

    fetch(32'h80000002, 0, 0, 2, 32'h0);

    // Flush while holding: inst_valid gated at once, no pc_ready.
    pc = 32'h80000001; pc_valid = 1'b1;
    tick();
    flush = 1'b1; pc_valid = 1'b0;
    #1;
    chk(inst_valid == 1'b0, "flush_hold_gated", 32'(inst_valid), 0);
    inst_ready = 1'b1;
    tick();
    flush = 1'b0; inst_ready = 1'b0;
    chk(inst_valid == 1'b0, "flush_hold_valid_low", 32'(inst_valid), 0);
    chk(pc_ready == 1'b0, "flush_hold_no_pc_ready", 32'(pc_ready), 0);
    tick();

    // Reset in WAIT, then a stray response after release.
    pc = 32'h80000020; pc_valid = 1'b1;
    tick();
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; pc_valid = 1'b0; rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    tick();
    rst_n = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h12345678;
    tick();
    imem_rvalid = 1'b0;
    chk_all_zero("stray_rvalid");
    tick();
    chk(inst_valid == 1'b0, "stray_rvalid_valid", 32'(inst_valid), 0);
    fetch(32'h80000024, 0, 0, 0, 32'h00000513);

`ifdef IFU_TIMEOUT_EN
    begin
      exp_t e;
      e.inst = NOP; e.pc = 32'h80000028; e.fault = 1'b1;
      sb.push_back(e);
      pc = 32'h80000028; pc_valid = 1'b1;
      tick();
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      for (int i = 0; i < 8; i++) begin
        chk(inst_valid == 1'b0, "timeout_waiting", 32'(inst_valid), 0);
        tick();
      end
      chk(inst_valid == 1'b1, "timeout_valid", 32'(inst_valid), 1);
      imem_rvalid = 1'b1; imem_rdata = 32'hBADC0DE0;
      tick();
      imem_rvalid = 1'b0;
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0; pc_valid = 1'b0;
      chk(pc_ready == 1'b1, "timeout_pc_ready", 32'(pc_ready), 1);
      tick();
      chk(inst_valid == 1'b0, "late_rvalid_ignored", 32'(inst_valid), 0);
    end
`endif

    tick();
    tick();
    chk(sb.size() == 0, "scoreboard_drained", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
